// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: ALU flag register layout and ALU instruction payload.
package gb_cpu_common_pkg;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_ADC = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SBC = 4'd4,
        ALU_AND = 4'd5,
        ALU_XOR = 4'd6,
        ALU_OR  = 4'd7,
        ALU_CP  = 4'd8
    } alu_op_t;

    typedef struct packed {
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_instruction_t;

endpackage

// File: rtl/gb_cpu_alu16_seq.sv
// 16-bit arithmetic sequencer: runs ADD HL,rr / ADD SP,e8 / INC rr / DEC rr
// as a low-byte pass followed by a high-byte pass through the 8-bit ALU.
module gb_cpu_alu16_seq
    import gb_cpu_common_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [15:0]      operand_a_i,
    input  logic [15:0]      operand_b_i,
    input  alu_flags_t       flags_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      result_o,
    output alu_flags_t       flags_o,
    output alu_instruction_t alu_instr_o,
    output alu_flags_t       alu_flags_o,
    input  logic [7:0]       alu_out_i,
    input  alu_flags_t       alu_flags_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD16   = 2'd0,
        OP_ADDSPE8 = 2'd1,
        OP_INC16   = 2'd2,
        OP_DEC16   = 2'd3
    } op_t;

    state_t     state;
    state_t     state_next;
    op_t        op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    alu_flags_t flags_q;
    logic [7:0] lo_byte;
    logic       lo_h;
    logic       lo_c;

    // Z and N from the ALU are never needed: Z is preserved or forced, N is fixed.
    logic unused_alu_flags;
    assign unused_alu_flags = alu_flags_i.z ^ alu_flags_i.n;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed four-cycle sequence once a start is accepted.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_i) state_next = S_LOW;
            S_LOW:  state_next = S_HIGH;
            S_HIGH: state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ALU drive: low byte uses a cleared carry, high byte chains the low-byte carry.
    always_comb begin
        alu_instr_o = '{op: ALU_NOP, a: 8'h00, b: 8'h00};
        alu_flags_o = flags_q;
        case (state)
            S_LOW: begin
                alu_instr_o.a = a_q[7:0];
                alu_flags_o   = '{z: flags_q.z, n: 1'b0, h: 1'b0, c: 1'b0};
                case (op_q)
                    OP_ADD16:   begin alu_instr_o.op = ALU_ADD; alu_instr_o.b = b_q[7:0]; end
                    OP_ADDSPE8: begin alu_instr_o.op = ALU_ADD; alu_instr_o.b = b_q[7:0]; end
                    OP_INC16:   begin alu_instr_o.op = ALU_ADD; alu_instr_o.b = 8'h01;    end
                    default:    begin alu_instr_o.op = ALU_SUB; alu_instr_o.b = 8'h01;    end
                endcase
            end
            S_HIGH: begin
                alu_instr_o.a = a_q[15:8];
                alu_flags_o   = '{z: flags_q.z, n: 1'b0, h: 1'b0, c: lo_c};
                case (op_q)
                    OP_ADD16:   begin alu_instr_o.op = ALU_ADC; alu_instr_o.b = b_q[15:8];     end
                    OP_ADDSPE8: begin alu_instr_o.op = ALU_ADC; alu_instr_o.b = {8{b_q[7]}};   end
                    OP_INC16:   begin alu_instr_o.op = ALU_ADC; alu_instr_o.b = 8'h00;         end
                    default:    begin alu_instr_o.op = ALU_SBC; alu_instr_o.b = 8'h00;         end
                endcase
            end
            default: ;
        endcase
    end

    // Operand capture, per-byte ALU results and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD16;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            flags_q  <= '0;
            lo_byte  <= 8'h00;
            lo_h     <= 1'b0;
            lo_c     <= 1'b0;
            result_o <= 16'h0000;
            flags_o  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            busy_o <= (state_next != S_IDLE);
            done_o <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_t'(op_i);
                        a_q     <= operand_a_i;
                        b_q     <= operand_b_i;
                        flags_q <= flags_i;
                    end
                end
                S_LOW: begin
                    lo_byte <= alu_out_i;
                    lo_h    <= alu_flags_i.h;
                    lo_c    <= alu_flags_i.c;
                end
                S_HIGH: begin
                    // High byte goes straight into the result so it is valid during DONE.
                    result_o <= {alu_out_i, lo_byte};
                    case (op_q)
                        OP_ADD16:   flags_o <= '{z: flags_q.z, n: 1'b0, h: alu_flags_i.h, c: alu_flags_i.c};
                        OP_ADDSPE8: flags_o <= '{z: 1'b0, n: 1'b0, h: lo_h, c: lo_c};
                        default:    flags_o <= flags_q;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
// Directed bench for gb_cpu_alu16_seq with a behavioural 8-bit ALU attached.
module tb_gb_cpu_alu16_seq;
    import gb_cpu_common_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [15:0]      operand_a;
    logic [15:0]      operand_b;
    alu_flags_t       flags_in;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    alu_flags_t       flags_out;
    alu_instruction_t alu_instr;
    alu_flags_t       alu_flags;
    logic [7:0]       alu_out;
    alu_flags_t       alu_fl;

    int vectors;
    int miscompares;

    gb_cpu_alu16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .op_i        (op),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .flags_i     (flags_in),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .flags_o     (flags_out),
        .alu_instr_o (alu_instr),
        .alu_flags_o (alu_flags),
        .alu_out_i   (alu_out),
        .alu_flags_i (alu_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU: ADD/ADC/SUB/SBC with half-carry from bit 3.
    logic [8:0] m_s;
    logic [4:0] m_hs;
    logic       m_ci;
    always_comb begin
        alu_out = 8'h00;
        alu_fl  = alu_flags;
        m_s     = 9'h000;
        m_hs    = 5'h00;
        m_ci    = 1'b0;
        case (alu_instr.op)
            ALU_ADD, ALU_ADC: begin
                m_ci    = (alu_instr.op == ALU_ADC) ? alu_flags.c : 1'b0;
                m_s     = {1'b0, alu_instr.a} + {1'b0, alu_instr.b} + 9'(m_ci);
                m_hs    = {1'b0, alu_instr.a[3:0]} + {1'b0, alu_instr.b[3:0]} + 5'(m_ci);
                alu_out = m_s[7:0];
                alu_fl  = '{z: (m_s[7:0] == 8'h00), n: 1'b0, h: m_hs[4], c: m_s[8]};
            end
            ALU_SUB, ALU_SBC: begin
                m_ci    = (alu_instr.op == ALU_SBC) ? alu_flags.c : 1'b0;
                m_s     = {1'b0, alu_instr.a} - {1'b0, alu_instr.b} - 9'(m_ci);
                m_hs    = {1'b0, alu_instr.a[3:0]} - {1'b0, alu_instr.b[3:0]} - 5'(m_ci);
                alu_out = m_s[7:0];
                alu_fl  = '{z: (m_s[7:0] == 8'h00), n: 1'b1, h: m_hs[4], c: m_s[8]};
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble the inputs after capture, return the cycle done_o was seen (bounded).
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, output int lat);
        op        = o;
        operand_a = a;
        operand_b = b;
        flags_in  = f;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        op        = o + 2'd1;
        operand_a = ~a;
        operand_b = ~b;
        flags_in  = ~f;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b done=%b, need 0 0", busy, done);
        end
        vectors++;
        if (result !== 16'h0000 || flags_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_data: result=%h flags=%b, need 0000 0000", result, flags_out);
        end
        vectors++;
        if (alu_instr !== 20'h00000 || alu_flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_alu: instr=%h flags=%b, need 00000 0000", alu_instr, alu_flags);
        end
    endtask

    task automatic test_add16();
        int lat;
        run_op(2'b00, 16'h0FFF, 16'h0001, 4'b1101, lat);
        vectors++;
        if (lat !== 3 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL add16_latency: lat=%0d busy=%b, need 3 1", lat, busy);
        end
        vectors++;
        if (result !== 16'h1000 || flags_out !== 4'b1010) begin
            miscompares++;
            $display("FAIL add16_0fff: result=%h flags=%b, need 1000 1010", result, flags_out);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL add16_pulse: done=%b busy=%b, need 0 0", done, busy);
        end
        tick();
        vectors++;
        if (result !== 16'h1000 || flags_out !== 4'b1010) begin
            miscompares++;
            $display("FAIL add16_hold: result=%h flags=%b, need 1000 1010", result, flags_out);
        end
        tick();
        run_op(2'b00, 16'hFFFF, 16'h0001, 4'b0000, lat);
        vectors++;
        if (lat !== 3 || result !== 16'h0000 || flags_out !== 4'b0011) begin
            miscompares++;
            $display("FAIL add16_ffff: lat=%0d result=%h flags=%b, need 3 0000 0011", lat, result, flags_out);
        end
        tick();
    endtask

    task automatic test_addspe8();
        int lat;
        run_op(2'b01, 16'h00FF, 16'h0001, 4'b1000, lat);
        vectors++;
        if (lat !== 3 || result !== 16'h0100 || flags_out !== 4'b0011) begin
            miscompares++;
            $display("FAIL addspe8_pos: lat=%0d result=%h flags=%b, need 3 0100 0011", lat, result, flags_out);
        end
        tick();
        run_op(2'b01, 16'h1000, 16'hABFF, 4'b1111, lat);
        vectors++;
        if (lat !== 3 || result !== 16'h0FFF || flags_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL addspe8_neg: lat=%0d result=%h flags=%b, need 3 0fff 0000", lat, result, flags_out);
        end
        tick();
    endtask

    task automatic test_incdec();
        int lat;
        run_op(2'b10, 16'hFFFF, 16'h5A5A, 4'b1010, lat);
        vectors++;
        if (lat !== 3 || result !== 16'h0000 || flags_out !== 4'b1010) begin
            miscompares++;
            $display("FAIL inc16_wrap: lat=%0d result=%h flags=%b, need 3 0000 1010", lat, result, flags_out);
        end
        tick();
        run_op(2'b11, 16'h0000, 16'hA5A5, 4'b0101, lat);
        vectors++;
        if (lat !== 3 || result !== 16'hFFFF || flags_out !== 4'b0101) begin
            miscompares++;
            $display("FAIL dec16_wrap: lat=%0d result=%h flags=%b, need 3 ffff 0101", lat, result, flags_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_res [3];
        int ndone;
        exp_res[0] = 16'h0100;
        exp_res[1] = 16'h0504;
        exp_res[2] = 16'h0908;
        ndone = 0;
        op        = 2'b00;
        operand_b = 16'h0010;
        flags_in  = 4'b0000;
        start     = 1'b1;
        for (int c = 0; c < 18; c++) begin
            operand_a = 16'(c * 16'h0101) + 16'h00F0;
            if (c == 12) start = 1'b0;
            tick();
            if (done) begin
                vectors++;
                if (ndone > 2 || result !== exp_res[ndone > 2 ? 2 : ndone]) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: result=%h, need %h", ndone, result,
                             exp_res[ndone > 2 ? 2 : ndone]);
                end
                ndone++;
            end
        end
        vectors++;
        if (ndone !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: ops=%0d, need 3", ndone);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int ndone;
        op        = 2'b00;
        operand_a = 16'h1234;
        operand_b = 16'h1111;
        flags_in  = 4'b1111;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || flags_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_out: busy=%b done=%b result=%h flags=%b, need 0 0 0000 0000",
                     busy, done, result, flags_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_nodone: pulses=%0d busy=%b, need 0 0", ndone, busy);
        end
        run_op(2'b11, 16'h1234, 16'h0000, 4'b0110, lat);
        vectors++;
        if (lat !== 3 || result !== 16'h1233 || flags_out !== 4'b0110) begin
            miscompares++;
            $display("FAIL midreset_recover: lat=%0d result=%h flags=%b, need 3 1233 0110",
                     lat, result, flags_out);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        op          = 2'b00;
        operand_a   = 16'h0000;
        operand_b   = 16'h0000;
        flags_in    = 4'b0000;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_add16();
        test_addspe8();
        test_incdec();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gb_cpu_alu16_seq.md
Name: gb_cpu_alu16_seq

Overview:
- Sequencer upstream of the 8-bit CPU ALU. Executes 16-bit arithmetic as two back-to-back 8-bit ALU passes: low byte first, then high byte with carry.
- Supported ops: ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr.
- Drives the ALU instruction and flag inputs, consumes the ALU result and flags, and returns a 16-bit result plus final flags to the control unit.

Parameters:
- None. Widths are fixed by gb_cpu_common_pkg.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- op_i  input  2  operation: 00 ADD16, 01 ADDSPE8, 10 INC16, 11 DEC16.
- operand_a_i  input  16  HL, SP or rr.
- operand_b_i  input  16  rr for ADD16; [7:0] = e8 for ADDSPE8; ignored for INC16/DEC16.
- flags_i  input  alu_flags_t  current F register.
- busy_o  output  1  high in LOW, HIGH and DONE states.
- done_o  output  1  one-cycle pulse; result_o and flags_o are valid in this cycle.
- result_o  output  16  16-bit result.
- flags_o  output  alu_flags_t  final flags.
- alu_instr_o  output  alu_instruction_t  opcode and operands to the ALU.
- alu_flags_o  output  alu_flags_t  flags_i presented to the ALU.
- alu_out_i  input  8  ALU out.
- alu_flags_i  input  alu_flags_t  ALU flags_o.

Behaviour:
- Reset: clock is clk; rst_n is asynchronous and active-low.
  - Asserting rst_n low forces state IDLE, busy_o=0, done_o=0, result_o=0, flags_o=0, and all captured registers to 0.
  - Reset mid-operation aborts the operation; done_o never pulses for it.
- FSM states: IDLE -> LOW -> HIGH -> DONE -> IDLE.
  - IDLE: on start_i=1, capture op_i, operand_a_i, operand_b_i and flags_i; go to LOW.
  - start_i in any state other than IDLE is ignored.
- Latency: start_i sampled at edge k. LOW occupies cycle k..k+1, HIGH occupies k+1..k+2, and done_o=1 during cycle k+2..k+3.
  - With start_i held high continuously, one operation is accepted every 4 cycles.
- IDLE and DONE ALU drive: alu_instr_o = {ALU_NOP, 0, 0}; alu_flags_o = captured flags.
- LOW stage ALU drive (A = captured a[7:0]):
  - ADD16: ADD with B = b[7:0].
  - ADDSPE8: ADD with B = e8.
  - INC16: ADD with B = 8'h01.
  - DEC16: SUB with B = 8'h01.
  - alu_flags_o = {Z: captured Z, N: 0, H: 0, C: 0}.
  - Register lo_byte = alu_out_i, lo_H = alu_flags_i.H, lo_C = alu_flags_i.C.
- HIGH stage ALU drive (A = captured a[15:8], alu_flags_o.C = lo_C):
  - ADD16: ADC with B = b[15:8].
  - ADDSPE8: ADC with B = {8{e8[7]}} (sign extension).
  - INC16: ADC with B = 8'h00.
  - DEC16: SBC with B = 8'h00.
  - Register hi_byte = alu_out_i, hi_H, hi_C.
- DONE: result_o = {hi_byte, lo_byte}. flags_o by op:
  - ADD16: Z = captured Z, N = 0, H = hi_H (carry from bit 11), C = hi_C (carry from bit 15).
  - ADDSPE8: Z = 0, N = 0, H = lo_H, C = lo_C. Low-byte unsigned add; the sign of e8 does not affect H or C.
  - INC16/DEC16: flags_o = captured flags_i, unchanged.
- result_o and flags_o are registered and hold their last values until the next DONE.
- Wrap-around is modulo 2^16 for all ops: 0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF.
- flags_i changing after capture has no effect on an operation in flight.

Test Plan:
- ADD16 a=0x0FFF, b=0x0001, flags_i Z=1 N=1 H=0 C=1 -> result_o=0x1000, flags_o Z=1 N=0 H=1 C=0; done_o exactly 3 cycles after the start edge, for 1 cycle.
- ADD16 a=0xFFFF, b=0x0001, flags_i=0000 -> result_o=0x0000, flags_o Z=0 N=0 H=1 C=1 (Z preserved, not computed).
- ADDSPE8 a=0x00FF, e8=0x01 -> 0x0100, Z=0 N=0 H=1 C=1. ADDSPE8 a=0x1000, e8=0xFF -> 0x0FFF, H=0 C=0.
- INC16 a=0xFFFF with flags_i Z=1 N=0 H=1 C=0 -> 0x0000, flags_o unchanged. DEC16 a=0x0000 -> 0xFFFF, flags_o unchanged.
- start_i held high for 12 cycles with varying operands -> exactly 3 operations. Operands present at cycles 1-3 after each accepted start are ignored.
- rst_n low while in HIGH -> outputs immediately 0 and busy_o=0; no done_o pulse. The next start after reset release completes normally.
